// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS generator/checker pair.
// Holds the default LFSR length and tap mask, the checker state enum
// and the feedback helper used by both sides of the link.
package prbs_pkg;

  // Default LFSR: x^5 + x^2 + 1, must match the generator's mask
  localparam int PRBS_WIDTH = 5;
  localparam logic [PRBS_WIDTH-1:0] PRBS_TAPS = 5'b10010;

  // Widest LFSR the feedback helper accepts
  localparam int PRBS_MAX_WIDTH = 32;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  // Feedback bit of a Fibonacci LFSR: parity of the tapped history bits.
  // Callers zero-extend their history and mask to PRBS_MAX_WIDTH bits.
  function automatic logic prbs_next(input logic [PRBS_MAX_WIDTH-1:0] r,
                                     input logic [PRBS_MAX_WIDTH-1:0] taps);
    return ^(r & taps);
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter: parameterised-width up counter that sticks at
// all-ones. A synchronous clear wins over a simultaneous increment.
module prbs_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones, clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS checker.
// In SEARCH the received bits are shifted into the local history until
// LOCK_COUNT consecutive bits agree with the local prediction; in LOCKED
// the history free-runs on its own prediction and mismatches are counted.
// Too many errors inside one LOSS_WINDOW of valid bits drops lock again.
// Optional macro PRBS_CHK_BIT_COUNT_EN adds bit_count, the saturating
// number of valid bits received while locked (for BER computation).
// WIDTH must not exceed prbs_pkg::PRBS_MAX_WIDTH.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH       = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS        = PRBS_TAPS,
  parameter int               LOCK_COUNT  = 16,
  parameter int               LOSS_WINDOW = 32,
  parameter int               LOSS_THRESH = 4,
  parameter int               ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 clear,
  output logic                 lock,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef PRBS_CHK_BIT_COUNT_EN
  ,
  output logic [31:0]          bit_count
`endif
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  prbs_state_t        state, state_n;
  logic [WIDTH-1:0]   r, r_n;
  logic [FILL_W-1:0]  fill_cnt, fill_cnt_n;
  logic [MATCH_W-1:0] match_cnt, match_cnt_n;
  logic [WIN_W-1:0]   win_cnt, win_cnt_n;
  logic [WERR_W-1:0]  win_err, win_err_n;
  logic               err_pulse_n;

  logic               pred;
  logic               mismatch;
  logic               err_inc;
  logic [MATCH_W-1:0] match_inc;
  logic [WERR_W-1:0]  win_err_inc;

  assign pred        = prbs_next(PRBS_MAX_WIDTH'(r), PRBS_MAX_WIDTH'(TAPS));
  assign mismatch    = in_bit ^ pred;
  assign match_inc   = match_cnt + MATCH_W'(1);
  assign win_err_inc = win_err + WERR_W'(mismatch);
  assign err_inc     = (state == LOCKED) && in_valid && mismatch;
  assign lock        = (state == LOCKED);

  // Next-state logic: acquisition in SEARCH, error tracking in LOCKED;
  // idle cycles hold everything and only let err_pulse fall
  always_comb begin
    state_n     = state;
    r_n         = r;
    fill_cnt_n  = fill_cnt;
    match_cnt_n = match_cnt;
    win_cnt_n   = win_cnt;
    win_err_n   = win_err;
    err_pulse_n = 1'b0;

    if (in_valid) begin
      case (state)
        SEARCH: begin
          r_n = {r[WIDTH-2:0], in_bit};
          if (fill_cnt < FILL_W'(WIDTH)) begin
            fill_cnt_n = fill_cnt + FILL_W'(1);
          end else if (!mismatch && (r != '0)) begin
            match_cnt_n = match_inc;
            if (match_inc == MATCH_W'(LOCK_COUNT)) begin
              state_n     = LOCKED;
              match_cnt_n = '0;
              win_cnt_n   = '0;
              win_err_n   = '0;
            end
          end else begin
            match_cnt_n = '0;
          end
        end

        LOCKED: begin
          r_n         = {r[WIDTH-2:0], pred};
          err_pulse_n = mismatch;
          if (mismatch && (win_err_inc >= WERR_W'(LOSS_THRESH))) begin
            state_n     = SEARCH;
            fill_cnt_n  = '0;
            match_cnt_n = '0;
            win_cnt_n   = '0;
            win_err_n   = '0;
          end else if (win_cnt == WIN_W'(LOSS_WINDOW - 1)) begin
            win_cnt_n = '0;
            win_err_n = '0;
          end else begin
            win_cnt_n = win_cnt + WIN_W'(1);
            win_err_n = win_err_inc;
          end
        end

        default: begin
          state_n = SEARCH;
        end
      endcase
    end
  end

  // State register for the FSM, history and acquisition/window counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      r         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      fill_cnt  <= fill_cnt_n;
      match_cnt <= match_cnt_n;
      win_cnt   <= win_cnt_n;
      win_err   <= win_err_n;
      err_pulse <= err_pulse_n;
    end
  end

  prbs_sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_inc),
    .clr  (clear),
    .count(err_count)
  );

`ifdef PRBS_CHK_BIT_COUNT_EN
  logic bit_inc;

  assign bit_inc = lock && in_valid;

  prbs_sat_counter #(
    .W(32)
  ) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (bit_inc),
    .clr  (clear),
    .count(bit_count)
  );
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench for prbs_checker.
// Two instances: dut0 with default parameters, dut1 with a 4-bit error
// counter and a loss threshold equal to the window for saturation tests.
// Stimulus pushes the reference model's expected outputs into a queue per
// instance; a monitor pops and compares one entry per clocked stimulus.
// Define PRBS_CHK_BIT_COUNT_EN to also check bit_count.
module tb_prbs_checker;

  localparam int WIDTH       = 5;
  localparam int TAPS_INT    = 'h12;
  localparam int LOCK_COUNT  = 16;
  localparam int LOSS_WINDOW = 32;

  typedef struct packed {
    logic        lock;
    logic        pulse;
    logic [15:0] errc;
    logic [31:0] bitc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid0 = 1'b0, in_bit0 = 1'b0, clear0 = 1'b0;
  logic        in_valid1 = 1'b0, in_bit1 = 1'b0, clear1 = 1'b0;
  logic        lock0, err_pulse0, lock1, err_pulse1;
  logic [15:0] err_count0;
  logic [3:0]  err_count1;
`ifdef PRBS_CHK_BIT_COUNT_EN
  logic [31:0] bit_count0, bit_count1;
`endif

  int tests = 0;
  int fails = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state, one slot per instance
  int          mLocked[2], mFill[2], mMatch[2], mWin[2], mWerr[2];
  int          mThresh[2];
  int unsigned mErrMax[2], mErr[2], mHist[2];
  longint      mBits[2];
  bit          mPulse[2];
  int unsigned gst[2];

  always #5 clk = ~clk;

  prbs_checker dut0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid0),
    .in_bit   (in_bit0),
    .clear    (clear0),
    .lock     (lock0),
    .err_pulse(err_pulse0),
    .err_count(err_count0)
`ifdef PRBS_CHK_BIT_COUNT_EN
    ,.bit_count(bit_count0)
`endif
  );

  prbs_checker #(
    .ERR_CNT_W  (4),
    .LOSS_WINDOW(32),
    .LOSS_THRESH(32)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid1),
    .in_bit   (in_bit1),
    .clear    (clear1),
    .lock     (lock1),
    .err_pulse(err_pulse1),
    .err_count(err_count1)
`ifdef PRBS_CHK_BIT_COUNT_EN
    ,.bit_count(bit_count1)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset(input int k);
    mLocked[k] = 0; mFill[k] = 0; mMatch[k] = 0; mWin[k] = 0; mWerr[k] = 0;
    mErr[k] = 0; mHist[k] = 0; mBits[k] = 0; mPulse[k] = 1'b0;
  endtask

  // Behavioural reference: applies the checker rules to one cycle
  task automatic modelStep(input int k, input bit v, input bit b, input bit clr);
    int unsigned histMask;
    int p;
    histMask = (32'd1 << WIDTH) - 1;
    p = 0;
    for (int i = 0; i < WIDTH; i++)
      if (((TAPS_INT >> i) & 1) != 0) p ^= int'((mHist[k] >> i) & 1);
    mPulse[k] = 1'b0;
    if (v) begin
      if (mLocked[k] == 0) begin
        if (mFill[k] < WIDTH) mFill[k]++;
        else if (int'(b) == p && (mHist[k] & histMask) != 0) begin
          mMatch[k]++;
          if (mMatch[k] == LOCK_COUNT) begin
            mLocked[k] = 1; mWin[k] = 0; mWerr[k] = 0;
          end
        end else mMatch[k] = 0;
        mHist[k] = ((mHist[k] << 1) | int'(b)) & histMask;
      end else begin
        if (mBits[k] < 64'hFFFF_FFFF) mBits[k]++;
        mHist[k] = ((mHist[k] << 1) | p) & histMask;
        if (int'(b) != p) begin
          mPulse[k] = 1'b1;
          if (mErr[k] < mErrMax[k]) mErr[k]++;
          mWerr[k]++;
          if (mWerr[k] >= mThresh[k]) begin
            mLocked[k] = 0; mFill[k] = 0; mMatch[k] = 0;
          end
        end
        if (mLocked[k] != 0) begin
          mWin[k]++;
          if (mWin[k] == LOSS_WINDOW) begin
            mWin[k] = 0; mWerr[k] = 0;
          end
        end
      end
    end
    if (clr) begin
      mErr[k] = 0; mBits[k] = 0;
    end
  endtask

  task automatic genNext(input int k, output bit b);
    int fb;
    fb = 0;
    for (int i = 0; i < WIDTH; i++)
      if (((TAPS_INT >> i) & 1) != 0) fb ^= int'((gst[k] >> i) & 1);
    gst[k] = ((gst[k] << 1) | fb) & ((32'd1 << WIDTH) - 1);
    b = bit'(fb);
  endtask

  // One clocked stimulus on instance k; the other instance idles
  task automatic applyStimulus(input int k, input bit v, input bit b, input bit clr);
    exp_t e;
    @(negedge clk);
    in_valid0 = (k == 0) ? v : 1'b0;
    in_bit0   = (k == 0) ? b : 1'b0;
    clear0    = (k == 0) ? clr : 1'b0;
    in_valid1 = (k == 1) ? v : 1'b0;
    in_bit1   = (k == 1) ? b : 1'b0;
    clear1    = (k == 1) ? clr : 1'b0;
    modelStep(k, v, b, clr);
    modelStep(1 - k, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 2; j++) begin
      e.lock  = (mLocked[j] != 0);
      e.pulse = mPulse[j];
      e.errc  = 16'(mErr[j]);
      e.bitc  = 32'(mBits[j]);
      if (j == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic sendGen(input int k, input bit v, input bit inj, input bit clr);
    bit b;
    if (v) begin
      genNext(k, b);
      b ^= inj;
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    applyStimulus(k, v, b, clr);
  endtask

  task automatic waitSample();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    in_valid0 = 1'b0; in_bit0 = 1'b0; clear0 = 1'b0;
    in_valid1 = 1'b0; in_bit1 = 1'b0; clear1 = 1'b0;
    modelReset(0);
    modelReset(1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_lock0", 32'(lock0), 32'd0);
    checkOutput("rst_pulse0", 32'(err_pulse0), 32'd0);
    checkOutput("rst_errc0", 32'(err_count0), 32'd0);
    checkOutput("rst_lock1", 32'(lock1), 32'd0);
    checkOutput("rst_errc1", 32'(err_count1), 32'd0);
  endtask

  // Monitor: compare DUT outputs with the queued model response
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checkOutput("sb_lock0", 32'(lock0), 32'(e.lock));
        checkOutput("sb_pulse0", 32'(err_pulse0), 32'(e.pulse));
        checkOutput("sb_errc0", 32'(err_count0), 32'(e.errc));
`ifdef PRBS_CHK_BIT_COUNT_EN
        checkOutput("sb_bitc0", bit_count0, e.bitc);
`endif
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput("sb_lock1", 32'(lock1), 32'(e.lock));
        checkOutput("sb_pulse1", 32'(err_pulse1), 32'(e.pulse));
        checkOutput("sb_errc1", 32'(err_count1), 32'(e.errc));
`ifdef PRBS_CHK_BIT_COUNT_EN
        checkOutput("sb_bitc1", bit_count1, e.bitc);
`endif
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nv;
    int sinceLock;
    mThresh[0] = 4;  mErrMax[0] = 65535;
    mThresh[1] = 32; mErrMax[1] = 15;
    modelReset(0);
    modelReset(1);

    doReset();

    // Clean lock with continuous valid
    gst[0] = 1;
    for (int n = 1; n <= 500; n++) begin
      sendGen(0, 1'b1, 1'b0, 1'b0);
      if (n == 20) begin
        waitSample();
        checkOutput("lock_after_20", 32'(lock0), 32'd0);
      end
      if (n == 21) begin
        waitSample();
        checkOutput("lock_after_21", 32'(lock0), 32'd1);
      end
    end
    waitSample();
    checkOutput("clean_errc", 32'(err_count0), 32'd0);

    // Reset after bits fed, then lock with valid every other cycle
    doReset();
    gst[0] = 1;
    nv = 0;
    while (nv < 300) begin
      sendGen(0, 1'b1, 1'b0, 1'b0);
      nv++;
      if (nv == 20) begin
        waitSample();
        checkOutput("toggle_lock_20", 32'(lock0), 32'd0);
      end
      if (nv == 21) begin
        waitSample();
        checkOutput("toggle_lock_21", 32'(lock0), 32'd1);
      end
      sendGen(0, 1'b0, 1'b0, 1'b0);
    end
    waitSample();
    checkOutput("toggle_errc", 32'(err_count0), 32'd0);

    // Single injected error while locked
    sendGen(0, 1'b1, 1'b1, 1'b0);
    waitSample();
    checkOutput("single_pulse", 32'(err_pulse0), 32'd1);
    sendGen(0, 1'b1, 1'b0, 1'b0);
    waitSample();
    checkOutput("single_pulse_off", 32'(err_pulse0), 32'd0);
    checkOutput("single_errc", 32'(err_count0), 32'd1);
    checkOutput("single_lock", 32'(lock0), 32'd1);
    for (int n = 0; n < 100; n++) sendGen(0, 1'b1, 1'b0, 1'b0);
    waitSample();
    checkOutput("single_errc_after", 32'(err_count0), 32'd1);

    // Loss of lock: four errors inside one window, then relock
    sendGen(0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 40 && mWin[0] != 0; n++) sendGen(0, 1'b1, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      sendGen(0, 1'b1, 1'b1, 1'b0);
      waitSample();
      checkOutput("loss_lock", 32'(lock0), (e < 3) ? 32'd1 : 32'd0);
      if (e < 3) sendGen(0, 1'b1, 1'b0, 1'b0);
    end
    for (int n = 1; n <= 21; n++) begin
      sendGen(0, 1'b1, 1'b0, 1'b0);
      if (n == 20) begin
        waitSample();
        checkOutput("relock_20", 32'(lock0), 32'd0);
      end
      if (n == 21) begin
        waitSample();
        checkOutput("relock_21", 32'(lock0), 32'd1);
      end
    end
    checkOutput("loss_errc", 32'(err_count0), 32'd4);

    // All-zero and all-one streams never lock
    doReset();
    for (int n = 0; n < 200; n++) applyStimulus(0, 1'b1, 1'b0, 1'b0);
    waitSample();
    checkOutput("zeros_lock", 32'(lock0), 32'd0);
    checkOutput("zeros_errc", 32'(err_count0), 32'd0);
    for (int n = 0; n < 200; n++) applyStimulus(0, 1'b1, 1'b1, 1'b0);
    waitSample();
    checkOutput("ones_lock", 32'(lock0), 32'd0);

    // Randomized valid, errors and clears against the model
    doReset();
    gst[0] = $urandom_range(1, 31);
    for (int n = 0; n < 1500; n++)
      sendGen(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 23) == 0),
              ($urandom_range(0, 63) == 0));

    // Saturation and clear on the 4-bit counter instance
    doReset();
    gst[1] = 1;
    for (int n = 1; n <= 21; n++) sendGen(1, 1'b1, 1'b0, 1'b0);
    waitSample();
    checkOutput("sat_lock", 32'(lock1), 32'd1);
    sinceLock = 0;
    for (int e = 0; e < 20; e++) begin
      sendGen(1, 1'b1, 1'b1, 1'b0);
      sinceLock++;
      for (int n = 0; n < 10; n++) begin
        sendGen(1, 1'b1, 1'b0, 1'b0);
        sinceLock++;
      end
    end
    waitSample();
    checkOutput("sat_errc", 32'(err_count1), 32'd15);
    checkOutput("sat_lock_kept", 32'(lock1), 32'd1);
`ifdef PRBS_CHK_BIT_COUNT_EN
    checkOutput("sat_bitc", bit_count1, 32'(sinceLock));
`endif
    sendGen(1, 1'b1, 1'b1, 1'b1);
    waitSample();
    checkOutput("clear_beats_inc", 32'(err_count1), 32'd0);
    checkOutput("clear_pulse", 32'(err_pulse1), 32'd1);
`ifdef PRBS_CHK_BIT_COUNT_EN
    checkOutput("clear_bitc", bit_count1, 32'd0);
`endif

    sendGen(1, 1'b0, 1'b0, 1'b0);
    sendGen(0, 1'b0, 1'b0, 1'b0);
    waitSample();
    waitSample();
    checkOutput("queue_drain", 32'(q0.size() + q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
